seg_scan: RTL and testbench
===========================

# seg_scan

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It takes a packed hex value plus per-digit decimal-point and blank controls and scans one digit at a time at a programmable refresh rate. Outputs are active-low one-hot digit selects and active-low segment data. New values are double-buffered so a displayed frame never mixes old and new digits. It sits between the recognition/result logic and the board's segment pins, generalising the single-digit hex decoder to N digits.

## Interface
- DIGITS, 6: number of digits scanned (1..8).
- SCAN_DIV, 50000: clock cycles each digit stays lit (>=1).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; capture value/dp_mask/blank_mask/lz_en into the shadow register.
- value  in  4*DIGITS  packed hex digits; digit i = value[4i+3:4i]; digit 0 is rightmost.
- dp_mask  in  DIGITS  1 = light decimal point of digit i.
- blank_mask  in  DIGITS  1 = force digit i segments off.
- lz_en  in  1  enable leading-zero suppression.
- seg_sel  out  DIGITS  active-low one-hot digit enable; digit i uses bit i.
- seg_data  out  8  active-low segments; bit7 = dp, bits6:0 = g..a.
- pending  out  1  shadow holds data not yet shown.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

## Operation
- Decode (active-low, dp bit = 1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Divider cnt counts 0..SCAN_DIV-1. At terminal count, idx advances (idx = DIGITS-1 wraps to 0) and cnt returns to 0.
- Shadow register: on load, value/masks/lz_en are written to it and pending is set. Last write wins while pending.
- Frame boundary (idx wrap): if pending, shadow is copied to active and pending clears. If load coincides with the boundary, the new inputs go straight to active and pending stays 0.
- Displayed digit i = idx:
  - seg_sel = all ones except bit i = 0.
  - If blank_mask[i] is set, or suppression applies to i, seg_data[6:0] = 7F. Otherwise seg_data[6:0] = decode(digit i).
  - seg_data[7] = ~dp_mask[i]. The decimal point shows even on a blanked digit.
- Leading-zero suppression (lz_en active): digit i>0 is suppressed when it and every digit above it are 0. Digit 0 is never suppressed. An all-zero value shows a single "0".

## Timing
- Reset values: cnt=0, idx=0, active and shadow value/masks=0, lz_en=0, pending=0, frame_tick=0, seg_sel=all ones, seg_data=FF.
- seg_sel and seg_data are registered, one cycle behind idx/active.
  - First cycle after reset release: outputs still FF / all ones.
  - Next cycle: digit 0 shows "0", seg_sel = ~1.
- Each digit is lit for exactly SCAN_DIV cycles; a full frame is DIGITS*SCAN_DIV cycles.
- frame_tick is high in the same cycle idx changes from DIGITS-1 to 0.
- Data loaded takes effect in the first output cycle of the next frame, at most DIGITS*SCAN_DIV+1 cycles after load.
- SCAN_DIV=1: idx advances every cycle. DIGITS=1: every terminal count is a frame boundary.
- rst asserted mid-frame returns all state to reset values on the next edge; any pending load is discarded.

## Structure
- Shared package seg_pkg:
  - SEG_BLANK = 8'hFF.
  - Decode function hex_to_seg (4-bit -> 7-bit active-low), shared with the existing single-digit decoder.
- Counter width is derived locally: $clog2(SCAN_DIV), minimum 1.
- One natural sub-module: seg_lz_mask (combinational, value + lz_en -> DIGITS-bit suppress vector).

## Test plan
Bench uses DIGITS=6, SCAN_DIV=4.
- Reset then idle -> seg_data = FF for 1 cycle; then seg_sel = 3E, seg_data = C0 for 4 cycles; digits 1-5 show C0 in turn; frame_tick every 24 cycles.
- load value=0x00A5F3, lz_en=1, dp_mask=0x04 mid-frame:
  - pending=1 until the next wrap.
  - Next frame shows digits 0..5 as B0, 8E, 92 with dp (12), 88, FF, FF.
- Two loads inside one frame (0x111111, then 0x222222) -> only A4 appears on all digits; 0x111111 is never displayed.
- load asserted on the frame_tick cycle with value 0x000007 -> next frame shows F8 on digit 0 and C0 elsewhere; pending stays 0.
- blank_mask=0x3F, dp_mask=0x01 -> digit 0 shows 7F, all others FF.
- rst pulsed while idx=3 and pending=1 -> next output is FF / all ones, then digit 0 shows C0; pending=0.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg
//   Shared definitions for the seven-segment display drivers.
//   SEG_BLANK  : full active-low pattern with every segment and the dp off.
//   SEG_OFF    : the seven segment bits (g..a) all off, dp excluded.
//   hex_to_seg : 4-bit hex nibble -> 7-bit active-low segment pattern (g..a).
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Active-low decode, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// seg_lz_mask
//   Combinational leading-zero suppression vector for a packed hex value.
//   value_i    : packed hex digits, digit i = value_i[4i+3:4i]
//   lz_en_i    : suppression enable
//   suppress_o : bit i set when digit i (i>0) and every digit above it are 0;
//                bit 0 is never set so an all-zero value still shows "0".
module seg_lz_mask #(
  parameter int DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] value_i,
  input  logic                lz_en_i,
  output logic [DIGITS-1:0]   suppress_o
);

  logic              zero_above_s;
  logic [DIGITS-1:0] suppress_s;

  // Walk from the most significant digit down, tracking "all zero so far".
  always_comb begin
    zero_above_s = 1'b1;
    suppress_s   = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above_s  = zero_above_s & (value_i[4*i +: 4] == 4'h0);
      suppress_s[i] = lz_en_i & zero_above_s;
    end
  end

  assign suppress_o = suppress_s;

endmodule

// File: rtl/seg_scan.sv
// seg_scan
//   Time-multiplexed driver for DIGITS common-anode seven-segment digits.
//   Each digit is lit for SCAN_DIV cycles; new data is double-buffered and
//   only becomes visible at a frame boundary.
//   clk, rst        : clock, synchronous active-high reset
//   load            : strobe capturing value/dp_mask/blank_mask/lz_en
//   value           : packed hex digits, digit 0 rightmost
//   dp_mask         : per-digit decimal point enable
//   blank_mask      : per-digit forced blank
//   lz_en           : leading-zero suppression enable
//   seg_sel         : active-low one-hot digit enable (registered)
//   seg_data        : active-low {dp, g..a} (registered)
//   pending         : shadow holds data not yet shown
//   frame_tick      : high in the cycle whose closing edge wraps idx to 0
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic                lz_en,
  output logic [DIGITS-1:0]   seg_sel,
  output logic [7:0]          seg_data,
  output logic                pending,
  output logic                frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tc_s, wrap_s;
  logic                frame_tick_q, frame_tick_d;
  logic                pending_q, pending_d;
  logic [4*DIGITS-1:0] act_value_q, act_value_d, sh_value_q, sh_value_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
  logic                act_lz_q, act_lz_d, sh_lz_q, sh_lz_d;
  logic [DIGITS-1:0]   suppress_s;
  logic [DIGITS-1:0]   seg_sel_q, seg_sel_d;
  logic [7:0]          seg_data_q, seg_data_d;
  logic [DIGITS-1:0]   hot_s;
  logic [3:0]          digit_s;
  logic                blank_s, dp_s, sup_s;

  seg_lz_mask #(.DIGITS(DIGITS)) u_lz_mask (
    .value_i    (act_value_q),
    .lz_en_i    (act_lz_q),
    .suppress_o (suppress_s)
  );

  // Scan divider and digit index; frame_tick is a look-ahead of the next wrap.
  always_comb begin
    tc_s   = (cnt_q == CW'(SCAN_DIV - 1));
    wrap_s = tc_s && (idx_q == IW'(DIGITS - 1));
    if (tc_s) begin
      cnt_d = {CW{1'b0}};
      if (wrap_s) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
    end
    frame_tick_d = (cnt_d == CW'(SCAN_DIV - 1)) && (idx_d == IW'(DIGITS - 1));
  end

  // Double buffer: loads park in the shadow, which is promoted on the wrap.
  // A load on the wrap itself bypasses the shadow.
  always_comb begin
    act_value_d = act_value_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_lz_d    = act_lz_q;
    sh_value_d  = sh_value_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    sh_lz_d     = sh_lz_q;
    pending_d   = pending_q;
    if (wrap_s) begin
      pending_d = 1'b0;
      if (load) begin
        act_value_d = value;
        act_dp_d    = dp_mask;
        act_blank_d = blank_mask;
        act_lz_d    = lz_en;
      end else if (pending_q) begin
        act_value_d = sh_value_q;
        act_dp_d    = sh_dp_q;
        act_blank_d = sh_blank_q;
        act_lz_d    = sh_lz_q;
      end else begin
        act_value_d = act_value_q;
      end
    end else if (load) begin
      sh_value_d = value;
      sh_dp_d    = dp_mask;
      sh_blank_d = blank_mask;
      sh_lz_d    = lz_en;
      pending_d  = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Select the current digit's attributes with an AND-OR mux over all digits.
  always_comb begin
    digit_s = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      hot_s[i] = (IW'(i) == idx_q);
      digit_s  = digit_s | (act_value_q[4*i +: 4] & {4{hot_s[i]}});
    end
    blank_s   = |(act_blank_q & hot_s);
    dp_s      = |(act_dp_q & hot_s);
    sup_s     = |(suppress_s & hot_s);
    seg_sel_d = ~hot_s;
    if (blank_s || sup_s) begin
      seg_data_d = {~dp_s, SEG_OFF};
    end else begin
      seg_data_d = {~dp_s, hex_to_seg(digit_s)};
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= {CW{1'b0}};
      idx_q        <= {IW{1'b0}};
      frame_tick_q <= 1'b0;
      pending_q    <= 1'b0;
      act_value_q  <= {(4*DIGITS){1'b0}};
      act_dp_q     <= {DIGITS{1'b0}};
      act_blank_q  <= {DIGITS{1'b0}};
      act_lz_q     <= 1'b0;
      sh_value_q   <= {(4*DIGITS){1'b0}};
      sh_dp_q      <= {DIGITS{1'b0}};
      sh_blank_q   <= {DIGITS{1'b0}};
      sh_lz_q      <= 1'b0;
      seg_sel_q    <= {DIGITS{1'b1}};
      seg_data_q   <= SEG_BLANK;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_tick_q <= frame_tick_d;
      pending_q    <= pending_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      act_lz_q     <= act_lz_d;
      sh_value_q   <= sh_value_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_lz_q      <= sh_lz_d;
      seg_sel_q    <= seg_sel_d;
      seg_data_q   <= seg_data_d;
    end
  end

  assign seg_sel    = seg_sel_q;
  assign seg_data   = seg_data_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan
//   Scoreboarded bench for seg_scan (DIGITS=6, SCAN_DIV=4). A reference model
//   keyed on a cycle count pushes the expected output for every cycle; a
//   monitor pops and compares on the falling edge.
module tb_seg_scan;

  localparam int D = 6;
  localparam int S = 4;
  localparam int F = D * S;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] data;
    logic       pend;
    logic       tick;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [23:0]   value;
  logic [5:0]    dp_mask, blank_mask;
  logic          lz_en;
  logic [5:0]    seg_sel;
  logic [7:0]    seg_data;
  logic          pending, frame_tick;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  // model state
  bit            started = 1'b0;
  int            c = 0;
  logic [23:0]   m_act_v, m_sh_v;
  logic [5:0]    m_act_dp, m_act_bl, m_sh_dp, m_sh_bl;
  logic          m_act_lz, m_sh_lz, m_pend;
  logic [7:0]    seg_tbl [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan #(.DIGITS(D), .SCAN_DIV(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .seg_sel    (seg_sel),
    .seg_data   (seg_data),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] show(int i);
    logic [23:0] upper;
    logic [3:0]  nib;
    logic [7:0]  pat;
    logic [6:0]  low;
    upper = m_act_v >> (4 * i);
    nib   = upper[3:0];
    pat   = seg_tbl[nib];
    if (m_act_bl[i] || (m_act_lz && i > 0 && upper == 24'h0)) low = 7'h7F;
    else low = pat[6:0];
    return {~m_act_dp[i], low};
  endfunction

  task automatic model_edge();
    exp_t e;
    int   i;
    if (rst) begin
      started  = 1'b1;
      c        = 0;
      m_act_v  = 24'h0; m_act_dp = 6'h0; m_act_bl = 6'h0; m_act_lz = 1'b0;
      m_sh_v   = 24'h0; m_sh_dp  = 6'h0; m_sh_bl  = 6'h0; m_sh_lz  = 1'b0;
      m_pend   = 1'b0;
      e.sel    = 6'h3F; e.data = 8'hFF; e.pend = 1'b0; e.tick = 1'b0;
      exp_q.push_back(e);
    end else if (started) begin
      i      = (c / S) % D;
      e.sel  = 6'h3F & ~(6'h01 << i);
      e.data = show(i);
      if (c % F == F - 1) begin
        if (load) begin
          m_act_v = value; m_act_dp = dp_mask; m_act_bl = blank_mask; m_act_lz = lz_en;
        end else if (m_pend) begin
          m_act_v = m_sh_v; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl; m_act_lz = m_sh_lz;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_sh_v = value; m_sh_dp = dp_mask; m_sh_bl = blank_mask; m_sh_lz = lz_en;
        m_pend = 1'b1;
      end
      c++;
      e.pend = m_pend;
      e.tick = (c % F == F - 1);
      exp_q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  task automatic check(string name, logic [7:0] got, logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg_sel", {2'b00, seg_sel}, {2'b00, e.sel});
      check("seg_data", seg_data, e.data);
      check("pending", {7'h0, pending}, {7'h0, e.pend});
      check("frame_tick", {7'h0, frame_tick}, {7'h0, e.tick});
    end
  end

  task automatic wait_pos(int p);
    int guard = 0;
    while ((c % F) != p && guard < 4 * F) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_load(logic [23:0] v, logic [5:0] dp, logic [5:0] bl, logic lz);
    load = 1'b1; value = v; dp_mask = dp; blank_mask = bl; lz_en = lz;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = 24'h0; dp_mask = 6'h0; blank_mask = 6'h0; lz_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * F + 5) @(negedge clk);

    // mid-frame load with suppression and a decimal point
    wait_pos(10);
    do_load(24'h00A5F3, 6'h04, 6'h00, 1'b1);
    repeat (2 * F) @(negedge clk);

    // two loads in one frame: only the second shows
    wait_pos(3);
    do_load(24'h111111, 6'h00, 6'h00, 1'b0);
    wait_pos(8);
    do_load(24'h222222, 6'h00, 6'h00, 1'b0);
    repeat (2 * F) @(negedge clk);

    // load on the frame boundary goes straight to active
    wait_pos(F - 1);
    do_load(24'h000007, 6'h00, 6'h00, 1'b0);
    repeat (F + 4) @(negedge clk);

    // all blank with dp on digit 0
    wait_pos(5);
    do_load(24'h123456, 6'h01, 6'h3F, 1'b0);
    repeat (2 * F) @(negedge clk);

    // randomized loads
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) begin
        load       = 1'b1;
        value      = 24'($urandom) >> (4 * $urandom_range(0, 6));
        dp_mask    = 6'($urandom);
        blank_mask = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
        lz_en      = 1'($urandom);
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    repeat (F) @(negedge clk);

    // reset while idx=3 with a pending load
    wait_pos(13);
    do_load(24'hABCDEF, 6'h3F, 6'h00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * F) @(negedge clk);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
